// File: rtl/circle_datapath.sv
// Datapath behind the circle-drawing controller: screen-clear sweep counters,
// midpoint-circle registers, octant coordinate generation and the VGA output register.
module circle_datapath #(
    parameter int         SCREEN_W  = 160,
    parameter int         SCREEN_H  = 120,
    parameter int         CENTRE_X  = 80,
    parameter int         CENTRE_Y  = 60,
    parameter int         RADIUS    = 40,
    parameter logic [2:0] COLOUR    = 3'b010,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       loadx,
    input  logic       loady,
    input  logic       initx,
    input  logic       inity,
    input  logic       init_crit,
    input  logic       init_offsetx,
    input  logic       init_offsety,
    input  logic       load_crit,
    input  logic       load_offsetx,
    input  logic       load_offsety,
    input  logic       sel,
    input  logic [3:0] pixel,
    input  logic       plot_in,
    output logic       xdone,
    output logic       ydone,
    output logic       crit_condition,
    output logic       offset_condition,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot_out
);

    localparam logic [7:0]        X_DONE    = 8'(SCREEN_W);
    localparam logic [6:0]        Y_DONE    = 7'(SCREEN_H);
    localparam logic [7:0]        RADIUS_U  = 8'(RADIUS);
    localparam logic signed [9:0] CRIT_INIT = 10'(1 - RADIUS);
    localparam logic signed [9:0] CX        = 10'(CENTRE_X);
    localparam logic signed [9:0] CY        = 10'(CENTRE_Y);
    localparam logic signed [9:0] W_LIM     = 10'(SCREEN_W);
    localparam logic signed [9:0] H_LIM     = 10'(SCREEN_H);

    logic [7:0]        xcount_reg;
    logic [6:0]        ycount_reg;
    logic [7:0]        offset_x_reg;
    logic [7:0]        offset_y_reg;
    logic signed [9:0] crit_reg;
    logic signed [9:0] crit_next;

    logic [7:0] x_out_reg;
    logic [6:0] y_out_reg;
    logic [2:0] colour_out_reg;
    logic       plot_out_reg;

    logic signed [9:0] ox_s;
    logic signed [9:0] oy_s;
    logic signed [9:0] cand_x [8];
    logic signed [9:0] cand_y [8];
    logic signed [9:0] coord_x;
    logic signed [9:0] coord_y;
    logic              valid_octant;
    logic              on_screen;

    assign xdone            = (xcount_reg == X_DONE);
    assign ydone            = (ycount_reg == Y_DONE);
    assign crit_condition   = (crit_reg <= 10'sd0);
    assign offset_condition = (offset_y_reg <= offset_x_reg);

    assign ox_s = signed'({2'b00, offset_x_reg});
    assign oy_s = signed'({2'b00, offset_y_reg});

    // Decision update from pre-update offsets; 10-bit wrap matches the register width.
    always_comb begin
        crit_next = crit_reg;
        if (crit_condition)
            crit_next = crit_reg + (oy_s <<< 1) + 10'sd3;
        else
            crit_next = crit_reg + ((oy_s - ox_s) <<< 1) + 10'sd5;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            xcount_reg   <= '0;
            ycount_reg   <= '0;
            offset_x_reg <= '0;
            offset_y_reg <= '0;
            crit_reg     <= '0;
        end else begin
            if (loadx)
                xcount_reg <= initx ? 8'd0 : xcount_reg + 8'd1;
            if (loady)
                ycount_reg <= inity ? 7'd0 : ycount_reg + 7'd1;
            if (init_offsetx)
                offset_x_reg <= RADIUS_U;
            else if (load_offsetx)
                offset_x_reg <= offset_x_reg - 8'd1;
            if (init_offsety)
                offset_y_reg <= 8'd0;
            else if (load_offsety)
                offset_y_reg <= offset_y_reg + 8'd1;
            if (init_crit)
                crit_reg <= CRIT_INIT;
            else if (load_crit)
                crit_reg <= crit_next;
        end
    end

    // Octant gi serves pixel code gi+1: odd octants swap the offsets,
    // octants 2..5 mirror in x and octants 4..7 mirror in y.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_octant
            localparam bit SWAP  = (gi % 2) == 1;
            localparam bit NEG_X = (gi >= 2) && (gi <= 5);
            localparam bit NEG_Y = (gi >= 4);
            logic signed [9:0] dx;
            logic signed [9:0] dy;
            assign dx = SWAP ? oy_s : ox_s;
            assign dy = SWAP ? ox_s : oy_s;
            assign cand_x[gi] = NEG_X ? (CX - dx) : (CX + dx);
            assign cand_y[gi] = NEG_Y ? (CY - dy) : (CY + dy);
        end
    endgenerate

    always_comb begin
        coord_x      = CX;
        coord_y      = CY;
        valid_octant = 1'b0;
        if ((pixel >= 4'd1) && (pixel <= 4'd8)) begin
            valid_octant = 1'b1;
            coord_x      = cand_x[3'(pixel - 4'd1)];
            coord_y      = cand_y[3'(pixel - 4'd1)];
        end
    end

    assign on_screen = (coord_x >= 10'sd0) && (coord_x < W_LIM) &&
                       (coord_y >= 10'sd0) && (coord_y < H_LIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            x_out_reg      <= '0;
            y_out_reg      <= '0;
            colour_out_reg <= '0;
            plot_out_reg   <= 1'b0;
        end else if (sel) begin
            x_out_reg      <= coord_x[7:0];
            y_out_reg      <= coord_y[6:0];
            colour_out_reg <= COLOUR;
            plot_out_reg   <= plot_in & valid_octant & on_screen;
        end else begin
            x_out_reg      <= xcount_reg;
            y_out_reg      <= ycount_reg;
            colour_out_reg <= BG_COLOUR;
            plot_out_reg   <= plot_in;
        end
    end

    assign x_out      = x_out_reg;
    assign y_out      = y_out_reg;
    assign colour_out = colour_out_reg;
    assign plot_out   = plot_out_reg;

endmodule
